// File: rtl/rf_pkg.sv
// Register-file write-back constants, source encoding and load-return entry type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

    localparam int ADDR_W     = 5;   // register pointer width
    localparam int DATA_W     = 8;   // register data width
    localparam int NUM_REGS   = 16;  // scoreboard entries; higher pointers never go pending
    localparam int LD_DEPTH   = 2;   // load-return FIFO depth, power of 2, at least 2
    localparam int STARVE_MAX = 3;   // ALU losses tolerated before the ALU is forced to win

    localparam logic [ADDR_W-1:0] OVF_REG = ADDR_W'(8);

    // Which writer owns the rf write port this cycle
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_LD   = 2'd1,
        WB_ALU  = 2'd2,
        WB_OVF  = 2'd3
    } wb_src_e;

    // One returning load: destination and data
    typedef struct packed {
        logic [ADDR_W-1:0] ptr;
        logic [DATA_W-1:0] data;
    } ld_entry_t;

    // Overflow flag widened to a register word (bit 0 carries the flag)
    function automatic logic [DATA_W-1:0] ovf_word(input logic b);
        return {{(DATA_W-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/rf_ld_fifo.sv
// Small generic FIFO holding returning loads until they win the rf write port.
// Latency: a pushed entry appears at the head the cycle after the push edge.
// Backpressure: none upstream; a push while full is accepted only if a pop happens the same cycle.
module rf_ld_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A pop frees the slot being written, so push-when-full is fine if a pop coincides
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage: contents are meaningless while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates load returns, ALU results and the overflow flag onto the single rf write port; tracks pending loads.
// Latency: grant and rf write are combinational in the request cycle; load returns wait one cycle in the FIFO.
// Backpressure: ALU via alu_ready; loads have none (dropped with sticky ld_err when the FIFO is full).
module rf_wb_scheduler
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_ptr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_issue_ptr,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_ptr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_full,
    output logic              ld_err,
    input  logic              ovf_valid,
    input  logic              ovf_bit,
    input  logic [ADDR_W-1:0] rd_ptr_a,
    input  logic [DATA_W-1:0] rd_ptr_b,
    input  logic              rd_const,
    output logic              hazard,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_ptr_w,
    output logic [DATA_W-1:0] rf_di
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

    wb_src_e           wb_src;
    logic [ADDR_W-1:0] wb_ptr;
    logic [DATA_W-1:0] wb_data;

    ld_entry_t         ld_in;
    ld_entry_t         ld_head;
    logic              ld_empty;
    logic              ld_pop;
    logic              ld_drop;

    logic [SC_W-1:0]     starve_cnt;
    logic                force_alu;
    logic                ovf_pend;
    logic                ovf_bit_q;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic                hz_a;
    logic                hz_b;
    logic [ADDR_W-1:0]   rd_b_ptr;
    logic                rd_b_unused;

    // Register 0 and pointers beyond the scoreboard never carry a pending load
    function automatic logic in_sb(input logic [ADDR_W-1:0] p);
        return (p != '0) && (int'(p) < NUM_REGS);
    endfunction

    assign ld_in.ptr  = ld_ptr;
    assign ld_in.data = ld_data;

    rf_ld_fifo #(
        .DEPTH (LD_DEPTH),
        .W     ($bits(ld_entry_t))
    ) u_ld_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (ld_valid),
        .push_dat (ld_in),
        .pop      (ld_pop),
        .pop_dat  (ld_head),
        .full     (ld_full),
        .empty    (ld_empty)
    );

    assign force_alu = alu_valid && (starve_cnt == SC_MAX);

    // Pick the single writer: forced ALU, else FIFO head, else ALU, else overflow; nobody during reset
    always_comb begin
        wb_src = WB_NONE;
        if (!reset) begin
            if (force_alu)          wb_src = WB_ALU;
            else if (!ld_empty)     wb_src = WB_LD;
            else if (alu_valid)     wb_src = WB_ALU;
            else if (ovf_pend)      wb_src = WB_OVF;
        end
    end

    // Route the winner onto the write port
    always_comb begin
        wb_ptr  = '0;
        wb_data = '0;
        case (wb_src)
            WB_LD: begin
                wb_ptr  = ld_head.ptr;
                wb_data = ld_head.data;
            end
            WB_ALU: begin
                wb_ptr  = alu_ptr;
                wb_data = alu_data;
            end
            WB_OVF: begin
                wb_ptr  = OVF_REG;
                wb_data = ovf_word(ovf_bit_q);
            end
            default: begin
                wb_ptr  = '0;
                wb_data = '0;
            end
        endcase
    end

    // A grant to register 0 is still consumed, but never reaches the rf
    assign rf_we     = (wb_src != WB_NONE) && (wb_ptr != '0);
    assign rf_ptr_w  = wb_ptr;
    assign rf_di     = wb_data;
    assign alu_ready = (wb_src == WB_ALU);
    assign ld_pop    = (wb_src == WB_LD);
    assign ld_drop   = ld_valid && ld_full && !ld_pop;

    // Count consecutive ALU losses, saturating; any win or idle ALU restarts it
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!alu_valid || alu_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SC_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Hold the latest overflow bit until written; a new one in the grant cycle stays pending
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_pend  <= 1'b0;
            ovf_bit_q <= 1'b0;
        end else if (ovf_valid) begin
            ovf_pend  <= 1'b1;
            ovf_bit_q <= ovf_bit;
        end else if (wb_src == WB_OVF) begin
            ovf_pend  <= 1'b0;
        end
    end

    // Sticky record that a load return was lost
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_err <= 1'b0;
        end else if (ld_drop) begin
            ld_err <= 1'b1;
        end
    end

    // Scoreboard update: retire the written load, then mark the newly issued one (younger load wins)
    always_comb begin
        pending_nxt = pending;
        if (ld_pop && in_sb(ld_head.ptr)) begin
            pending_nxt[ld_head.ptr[IDX_W-1:0]] = 1'b0;
        end
        if (ld_issue && in_sb(ld_issue_ptr)) begin
            pending_nxt[ld_issue_ptr[IDX_W-1:0]] = 1'b1;
        end
    end

    // Scoreboard state
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Operand B carries a pointer only in its low bits; the rest is a constant payload
    assign rd_b_ptr    = rd_ptr_b[ADDR_W-1:0];
    assign rd_b_unused = ^rd_ptr_b[DATA_W-1:ADDR_W];

    // Stall decode while either source register waits on a load
    always_comb begin
        hz_a = in_sb(rd_ptr_a) && pending[rd_ptr_a[IDX_W-1:0]];
        hz_b = !rd_const && in_sb(rd_b_ptr) && pending[rd_b_ptr[IDX_W-1:0]];
    end

    assign hazard = hz_a || hz_b;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: expectations are pushed when stimulus is applied and checked half a cycle later.
// Backpressure: the bench holds an ALU request until the model says it was granted.
module tb_rf_wb_scheduler;

    localparam int T_DEPTH = 2;
    localparam int T_SMAX  = 3;
    localparam int T_NREG  = 16;
    localparam int T_OVF   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alu_valid = 1'b0;
    logic       alu_ready;
    logic [4:0] alu_ptr = '0;
    logic [7:0] alu_data = '0;
    logic       ld_issue = 1'b0;
    logic [4:0] ld_issue_ptr = '0;
    logic       ld_valid = 1'b0;
    logic [4:0] ld_ptr = '0;
    logic [7:0] ld_data = '0;
    logic       ld_full;
    logic       ld_err;
    logic       ovf_valid = 1'b0;
    logic       ovf_bit = 1'b0;
    logic [4:0] rd_ptr_a = '0;
    logic [7:0] rd_ptr_b = '0;
    logic       rd_const = 1'b0;
    logic       hazard;
    logic       rf_we;
    logic [4:0] rf_ptr_w;
    logic [7:0] rf_di;

    rf_wb_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_ptr      (alu_ptr),
        .alu_data     (alu_data),
        .ld_issue     (ld_issue),
        .ld_issue_ptr (ld_issue_ptr),
        .ld_valid     (ld_valid),
        .ld_ptr       (ld_ptr),
        .ld_data      (ld_data),
        .ld_full      (ld_full),
        .ld_err       (ld_err),
        .ovf_valid    (ovf_valid),
        .ovf_bit      (ovf_bit),
        .rd_ptr_a     (rd_ptr_a),
        .rd_ptr_b     (rd_ptr_b),
        .rd_const     (rd_const),
        .hazard       (hazard),
        .rf_we        (rf_we),
        .rf_ptr_w     (rf_ptr_w),
        .rf_di        (rf_di)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       alu_valid;
        bit [4:0] alu_ptr;
        bit [7:0] alu_data;
        bit       ld_issue;
        bit [4:0] ld_issue_ptr;
        bit       ld_valid;
        bit [4:0] ld_ptr;
        bit [7:0] ld_data;
        bit       ovf_valid;
        bit       ovf_bit;
        bit [4:0] rd_ptr_a;
        bit [7:0] rd_ptr_b;
        bit       rd_const;
    } stim_t;

    typedef struct {
        bit rst;
        bit we;
        bit alu_ready;
        bit hazard;
        bit full;
        bit err;
    } cyc_t;

    typedef struct {
        bit [4:0] ptr;
        bit [7:0] data;
    } wr_t;

    cyc_t cyc_q[$];
    wr_t  wr_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    wr_t ldq[$];
    bit  pend[32];
    bit  m_ovf_p;
    bit  m_ovf_b;
    bit  m_err;
    int  m_starve;
    bit  alu_granted;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic bit pend_at(input bit [4:0] p);
        return (p != 0) && (int'(p) < T_NREG) && pend[p];
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Apply one cycle of stimulus, predict this cycle's outputs, advance the model
    task automatic step(input stim_t s);
        cyc_t c;
        wr_t  w;
        bit   g_ld, g_alu, g_ovf;
        @(posedge clk);
        #1;
        reset        = s.rst;
        alu_valid    = s.alu_valid;
        alu_ptr      = s.alu_ptr;
        alu_data     = s.alu_data;
        ld_issue     = s.ld_issue;
        ld_issue_ptr = s.ld_issue_ptr;
        ld_valid     = s.ld_valid;
        ld_ptr       = s.ld_ptr;
        ld_data      = s.ld_data;
        ovf_valid    = s.ovf_valid;
        ovf_bit      = s.ovf_bit;
        rd_ptr_a     = s.rd_ptr_a;
        rd_ptr_b     = s.rd_ptr_b;
        rd_const     = s.rd_const;

        g_ld = 0; g_alu = 0; g_ovf = 0;
        if (!s.rst) begin
            if (s.alu_valid && m_starve >= T_SMAX) g_alu = 1;
            else if (ldq.size() != 0)              g_ld  = 1;
            else if (s.alu_valid)                  g_alu = 1;
            else if (m_ovf_p)                      g_ovf = 1;
        end
        w = '{ptr: 0, data: 0};
        if (g_ld)  w = ldq[0];
        if (g_alu) w = '{ptr: s.alu_ptr, data: s.alu_data};
        if (g_ovf) w = '{ptr: 5'(T_OVF), data: {7'b0, m_ovf_b}};

        c.rst       = s.rst;
        c.we        = (g_ld || g_alu || g_ovf) && (w.ptr != 0);
        c.alu_ready = g_alu;
        c.hazard    = pend_at(s.rd_ptr_a) || (!s.rd_const && pend_at(s.rd_ptr_b[4:0]));
        c.full      = (ldq.size() == T_DEPTH);
        c.err       = m_err;
        cyc_q.push_back(c);
        if (c.we) wr_q.push_back(w);
        alu_granted = g_alu;

        if (s.rst) begin
            ldq.delete();
            foreach (pend[i]) pend[i] = 0;
            m_ovf_p = 0; m_ovf_b = 0; m_err = 0; m_starve = 0;
        end else begin
            if (g_ld) begin
                pend[ldq[0].ptr] = 0;
                void'(ldq.pop_front());
            end
            if (s.ld_valid) begin
                if (ldq.size() < T_DEPTH) ldq.push_back('{ptr: s.ld_ptr, data: s.ld_data});
                else m_err = 1;
            end
            if (s.ld_issue && s.ld_issue_ptr != 0 && int'(s.ld_issue_ptr) < T_NREG) pend[s.ld_issue_ptr] = 1;
            if (s.ovf_valid) begin
                m_ovf_p = 1;
                m_ovf_b = s.ovf_bit;
            end else if (g_ovf) begin
                m_ovf_p = 0;
            end
            if (!s.alu_valid || g_alu) m_starve = 0;
            else if (m_starve < T_SMAX) m_starve++;
        end
    endtask

    // Monitor: compare each predicted cycle against the DUT, away from the clock edge
    always @(negedge clk) begin
        cyc_t e;
        wr_t  w;
        if (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            chk("rf_we", int'(rf_we), int'(e.we));
            chk("alu_ready", int'(alu_ready), int'(e.alu_ready));
            if (!e.rst) begin
                chk("hazard", int'(hazard), int'(e.hazard));
                chk("ld_full", int'(ld_full), int'(e.full));
                chk("ld_err", int'(ld_err), int'(e.err));
            end
            if (e.we && wr_q.size() != 0) begin
                w = wr_q.pop_front();
                if (rf_we) begin
                    chk("rf_ptr_w", int'(rf_ptr_w), int'(w.ptr));
                    chk("rf_di", int'(rf_di), int'(w.data));
                end
            end
        end
    end

    initial begin
        stim_t s;
        bit    alu_req;
        bit [4:0] ap;
        bit [7:0] ad;
        int    ld_pct;

        alu_req = 0; ap = 0; ad = 0; ld_pct = 50;
        alu_granted = 0;

        // Reset then idle
        s = idle(); s.rst = 1;
        step(s); step(s);
        repeat (5) step(idle());

        // Load to r3 raises a hazard until its data is written back
        s = idle(); s.ld_issue = 1; s.ld_issue_ptr = 3; step(s);
        s = idle(); s.rd_ptr_a = 3; step(s);
        s = idle(); s.rd_ptr_a = 3; s.ld_valid = 1; s.ld_ptr = 3; s.ld_data = 8'h5A; step(s);
        s = idle(); s.rd_ptr_a = 3; step(s);
        s = idle(); s.rd_ptr_a = 3; s.rd_ptr_b = 8'hE3; s.rd_const = 1; step(s);

        // FIFO head beats the ALU, which follows next cycle
        s = idle(); s.ld_valid = 1; s.ld_ptr = 2; s.ld_data = 8'h22; step(s);
        s = idle(); s.alu_valid = 1; s.alu_ptr = 4; s.alu_data = 8'h44; step(s);
        s = idle(); s.alu_valid = 1; s.alu_ptr = 4; s.alu_data = 8'h44; step(s);

        // Continuous load returns with a held ALU: starvation forcing, FIFO fill and drop
        for (int i = 0; i < 12; i++) begin
            s = idle();
            s.alu_valid = 1; s.alu_ptr = 5'(5 + (i % 3)); s.alu_data = 8'(8'h50 + i);
            s.ld_valid = 1; s.ld_ptr = 5'(9 + (i % 4)); s.ld_data = 8'(8'hA0 + i);
            step(s);
        end

        // Overflow raised while the ALU keeps the port busy; written once everything idles
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.alu_valid = 1; s.alu_ptr = 7; s.alu_data = 8'(i);
            s.ovf_valid = (i == 0); s.ovf_bit = 1;
            step(s);
        end
        step(idle());
        step(idle());

        // ALU write to register 0 is acknowledged but not written
        s = idle(); s.alu_valid = 1; s.alu_ptr = 0; s.alu_data = 8'hFF; step(s);
        step(idle());

        // Reset in the middle of queued loads and pending registers
        s = idle(); s.ld_issue = 1; s.ld_issue_ptr = 6; s.ld_valid = 1; s.ld_ptr = 6; s.ld_data = 8'h66; s.alu_valid = 1; s.alu_ptr = 1; step(s);
        s = idle(); s.ld_valid = 1; s.ld_ptr = 6; s.ld_data = 8'h67; s.alu_valid = 1; s.alu_ptr = 1; s.ovf_valid = 1; step(s);
        s = idle(); s.rst = 1; step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.rd_ptr_a = 6; s.rd_ptr_b = 8'h06; step(s);
        end

        // Randomized traffic with bursty load-return rates
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ld_pct = ($urandom_range(0, 1) == 1) ? 90 : 30;
            if (!alu_req && $urandom_range(0, 99) < 55) begin
                alu_req = 1;
                ap = 5'($urandom_range(0, 20));
                ad = 8'($urandom);
            end
            s = idle();
            s.rst          = ($urandom_range(0, 499) == 0);
            s.alu_valid    = alu_req;
            s.alu_ptr      = ap;
            s.alu_data     = ad;
            s.ld_issue     = ($urandom_range(0, 99) < 30);
            s.ld_issue_ptr = 5'($urandom_range(0, 20));
            s.ld_valid     = ($urandom_range(0, 99) < ld_pct);
            s.ld_ptr       = 5'($urandom_range(0, 20));
            s.ld_data      = 8'($urandom);
            s.ovf_valid    = ($urandom_range(0, 99) < 10);
            s.ovf_bit      = 1'($urandom_range(0, 1));
            s.rd_ptr_a     = 5'($urandom_range(0, 20));
            s.rd_ptr_b     = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 20))};
            s.rd_const     = 1'($urandom_range(0, 1));
            step(s);
            if (alu_granted) alu_req = 0;
        end

        step(idle());
        @(negedge clk);
        #1;
        chk("cycles_left", cyc_q.size(), 0);
        chk("writes_left", wr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
